rbt_seadp_hdr_parser: RTL

RBT_SEADP_HDR_PARSER -- requirements
Module: rbt_seadp_hdr_parser

---
 rtl/rbt_seadp_hdr_parser.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rbt_seadp_hdr_parser.sv
// SEADP transport-header parser: two-stage valid/ready pipeline that extracts
// SEADP fields, validates the header length and destination port, tags errored
// packets in metadata and keeps saturating packet/error statistics.
module rbt_seadp_hdr_parser #(
    parameter int unsigned HEADER_WIDTH       = 2048,
    parameter int unsigned PKT_METADATA_WIDTH = 272
) (
    input  logic                          clk,
    input  logic                          rst,
    // upstream
    input  logic                          in_proto_hdr_valid,
    output logic                          in_proto_hdr_ready,
    input  logic [HEADER_WIDTH-1:0]       in_proto_hdr_data,
    input  logic [15:0]                   in_proto_hdr_length,
    input  logic [PKT_METADATA_WIDTH-1:0] in_proto_hdr_pkt_metadata,
    // downstream
    output logic                          out_proto_hdr_valid,
    input  logic                          out_proto_hdr_ready,
    output logic [HEADER_WIDTH-1:0]       out_proto_hdr_data,
    output logic [15:0]                   out_proto_hdr_length,
    output logic [PKT_METADATA_WIDTH-1:0] out_proto_hdr_pkt_metadata,
    // extracted fields
    output logic [15:0]                   out_seadp_src_port,
    output logic [15:0]                   out_seadp_dst_port,
    output logic [7:0]                    out_seadp_flags,
    output logic [7:0]                    out_seadp_hdr_len,
    output logic [31:0]                   out_seadp_pkt_num,
    // statistics
    output logic [31:0]                   stat_seadp_cnt,
    output logic [31:0]                   stat_err_cnt
);

    // PROTO_NO base 40 + SEADP index 12, and + ERROR index 31
    localparam int unsigned SeadpBit  = 52;
    localparam int unsigned ErrorBit  = 71;
    localparam logic [7:0]  MinHdrLen = 8'd12;
    localparam logic [31:0] CntMax    = 32'hFFFF_FFFF;

    // stage 1
    logic                          s1_valid_q;
    logic [HEADER_WIDTH-1:0]       s1_data_q;
    logic [15:0]                   s1_len_q;
    logic [PKT_METADATA_WIDTH-1:0] s1_meta_q;
    logic                          s1_seadp_q;
    logic [15:0]                   s1_src_q;
    logic [15:0]                   s1_dst_q;
    logic [7:0]                    s1_flags_q;
    logic [7:0]                    s1_hlen_q;
    logic [31:0]                   s1_pnum_q;

    // stage 2
    logic                          s2_valid_q;
    logic [HEADER_WIDTH-1:0]       s2_data_q;
    logic [15:0]                   s2_len_q;
    logic [PKT_METADATA_WIDTH-1:0] s2_meta_q;
    logic [15:0]                   s2_src_q;
    logic [15:0]                   s2_dst_q;
    logic [7:0]                    s2_flags_q;
    logic [7:0]                    s2_hlen_q;
    logic [31:0]                   s2_pnum_q;

    logic [31:0]                   seadp_cnt_q;
    logic [31:0]                   err_cnt_q;

    logic                          s1_ready;
    logic                          s2_ready;
    logic                          s1_load;
    logic                          s2_load;
    logic                          in_seadp;
    logic [15:0]                   in_src;
    logic [15:0]                   in_dst;
    logic [7:0]                    in_flags;
    logic [7:0]                    in_hlen;
    logic [31:0]                   in_pnum;
    logic                          s1_err;
    logic [PKT_METADATA_WIDTH-1:0] s1_meta_upd;

    assign s2_ready = !s2_valid_q || out_proto_hdr_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign s1_load  = in_proto_hdr_valid && s1_ready;
    assign s2_load  = s1_valid_q && s2_ready;
    assign in_seadp = in_proto_hdr_pkt_metadata[SeadpBit];

    // Ready is reported high during reset since both stages are being emptied;
    // the reset branch of the stage registers keeps anything from being taken.
    assign in_proto_hdr_ready = rst || s1_ready;

    // Field extraction from the big-endian header; non-SEADP packets carry zeros.
    always_comb begin
        in_src   = '0;
        in_dst   = '0;
        in_flags = '0;
        in_hlen  = '0;
        in_pnum  = '0;
        if (in_seadp) begin
            in_src   = in_proto_hdr_data[HEADER_WIDTH-1  -: 16];
            in_dst   = in_proto_hdr_data[HEADER_WIDTH-17 -: 16];
            in_flags = in_proto_hdr_data[HEADER_WIDTH-33 -: 8];
            in_hlen  = in_proto_hdr_data[HEADER_WIDTH-41 -: 8];
            in_pnum  = in_proto_hdr_data[HEADER_WIDTH-49 -: 32];
        end
    end

    // Header sanity check on the stage-1 fields and the resulting metadata.
    always_comb begin
        s1_err = s1_seadp_q &&
                 ((s1_hlen_q < MinHdrLen) ||
                  ({8'd0, s1_hlen_q} > s1_len_q) ||
                  (s1_dst_q == 16'd0));
        s1_meta_upd = s1_meta_q;
        if (s1_err) begin
            s1_meta_upd[ErrorBit] = 1'b1;
        end
    end

    // Stage 1 register: captures the accepted beat and its extracted fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_len_q   <= '0;
            s1_meta_q  <= '0;
            s1_seadp_q <= 1'b0;
            s1_src_q   <= '0;
            s1_dst_q   <= '0;
            s1_flags_q <= '0;
            s1_hlen_q  <= '0;
            s1_pnum_q  <= '0;
        end else begin
            // s1_ready means the slot is empty or draining this cycle
            if (s1_ready) begin
                s1_valid_q <= in_proto_hdr_valid;
            end
            if (s1_load) begin
                s1_data_q  <= in_proto_hdr_data;
                s1_len_q   <= in_proto_hdr_length;
                s1_meta_q  <= in_proto_hdr_pkt_metadata;
                s1_seadp_q <= in_seadp;
                s1_src_q   <= in_src;
                s1_dst_q   <= in_dst;
                s1_flags_q <= in_flags;
                s1_hlen_q  <= in_hlen;
                s1_pnum_q  <= in_pnum;
            end
        end
    end

    // Stage 2 register: holds the output beat until downstream takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_len_q   <= '0;
            s2_meta_q  <= '0;
            s2_src_q   <= '0;
            s2_dst_q   <= '0;
            s2_flags_q <= '0;
            s2_hlen_q  <= '0;
            s2_pnum_q  <= '0;
        end else begin
            if (s2_ready) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s2_load) begin
                s2_data_q  <= s1_data_q;
                s2_len_q   <= s1_len_q;
                s2_meta_q  <= s1_meta_upd;
                s2_src_q   <= s1_src_q;
                s2_dst_q   <= s1_dst_q;
                s2_flags_q <= s1_flags_q;
                s2_hlen_q  <= s1_hlen_q;
                s2_pnum_q  <= s1_pnum_q;
            end
        end
    end

    // Saturating statistics, counted as a packet moves into stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            seadp_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (s2_load && s1_seadp_q) begin
            if (seadp_cnt_q != CntMax) begin
                seadp_cnt_q <= seadp_cnt_q + 32'd1;
            end
            if (s1_err && (err_cnt_q != CntMax)) begin
                err_cnt_q <= err_cnt_q + 32'd1;
            end
        end
    end

    assign out_proto_hdr_valid        = s2_valid_q && !rst;
    assign out_proto_hdr_data         = s2_data_q;
    assign out_proto_hdr_length       = s2_len_q;
    assign out_proto_hdr_pkt_metadata = s2_meta_q;
    assign out_seadp_src_port         = s2_src_q;
    assign out_seadp_dst_port         = s2_dst_q;
    assign out_seadp_flags            = s2_flags_q;
    assign out_seadp_hdr_len          = s2_hlen_q;
    assign out_seadp_pkt_num          = s2_pnum_q;
    assign stat_seadp_cnt             = seadp_cnt_q;
    assign stat_err_cnt               = err_cnt_q;

endmodule
